// File: rtl/gemm_core.sv
// GEMM execution core: walks a two-level loop over a micro-op range, doing a
// 16x16 int8 matrix-vector MAC into int32 accumulator rows. Build option GEMM_CORE_SAT_EN.
module gemm_core #(
    parameter int UOP_WIDTH = 32,
    parameter int UPC_WIDTH = 13,
    parameter int INS_WIDTH = 128,
    parameter int INP_WIDTH = 8,
    parameter int WGT_WIDTH = 8,
    parameter int ACC_WIDTH = 32,
    parameter int INP_DEPTH = 16,
    parameter int WGT_DEPTH = 256,
    parameter int ACC_DEPTH = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [INS_WIDTH-1:0]             insn_i,
    input  logic [UOP_WIDTH-1:0]             uop_i,
    output logic [UPC_WIDTH-1:0]             upc_o,
    input  logic [ACC_DEPTH*ACC_WIDTH-1:0]   acc_mem_rd_data_i,
    output logic [11:0]                      acc_mem_rd_addr_o,
    output logic [ACC_DEPTH*ACC_WIDTH-1:0]   acc_mem_wr_data_o,
    output logic [11:0]                      acc_mem_wr_addr_o,
    output logic [ACC_DEPTH*ACC_WIDTH/8-1:0] acc_mem_wr_we_o,
    input  logic [INP_DEPTH*INP_WIDTH-1:0]   inp_mem_rd_data_i,
    output logic [31:0]                      inp_mem_rd_addr_o,
    input  logic [WGT_DEPTH*WGT_WIDTH-1:0]   wgt_mem_rd_data_i,
    output logic [31:0]                      wgt_mem_rd_addr_o,
    output logic [ACC_DEPTH*INP_WIDTH-1:0]   out_mem_wr_data_o,
    output logic [31:0]                      out_mem_wr_addr_o,
    output logic [31:0]                      out_mem_wr_we_o
);

    localparam int PW = INP_WIDTH + WGT_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = 127;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UOP,
        ST_IDX,
        ST_RD,
        ST_EXE,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic                 reset_reg_q;
    logic [12:0]          bgn_q;
    logic [13:0]          end_q, iter_out_q, iter_in_q;
    logic [10:0]          dfo_q, dfi_q, sfo_q, sfi_q;
    logic [9:0]           wfo_q, wfi_q;
    logic [13:0]          it_out_q, it_in_q;
    logic [UPC_WIDTH-1:0] upc_q;
    logic [31:0]          acc_idx_q, inp_idx_q, wgt_idx_q;
    logic [31:0]          acc_idx_d, inp_idx_d, wgt_idx_d;

    logic [ACC_DEPTH*ACC_WIDTH-1:0] acc_wr_data_q, exe_acc_d;
    logic [ACC_DEPTH*INP_WIDTH-1:0] out_wr_data_q, exe_out_d;
    logic [11:0]                    acc_wr_addr_q;
    logic                           we_q;

    logic is_gemm, degenerate, last_upc, last_in, last_out, last_step;
    logic unused_insn_bits;

    assign unused_insn_bits = ^{insn_i[6:3], insn_i[127]};

    assign is_gemm    = (insn_i[2:0] == 3'd2);
    assign degenerate = ({1'b0, insn_i[20:8]} >= insn_i[34:21]) ||
                        (insn_i[48:35] == 14'd0) || (insn_i[62:49] == 14'd0);
    assign last_upc   = (({1'b0, upc_q} + 14'd1) == end_q);
    assign last_in    = ((it_in_q + 14'd1) == iter_in_q);
    assign last_out   = ((it_out_q + 14'd1) == iter_out_q);
    assign last_step  = last_upc && last_in && last_out;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (is_gemm) state_d = degenerate ? ST_DONE : ST_UOP;
            ST_UOP:  state_d = ST_IDX;
            ST_IDX:  state_d = ST_RD;
            ST_RD:   state_d = ST_EXE;
            ST_EXE:  state_d = last_step ? ST_DONE : ST_UOP;
            ST_DONE: if (!is_gemm) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_idx_d = 32'(uop_i[10:0])  + 32'(it_out_q) * 32'(dfo_q) + 32'(it_in_q) * 32'(dfi_q);
        inp_idx_d = 32'(uop_i[21:11]) + 32'(it_out_q) * 32'(sfo_q) + 32'(it_in_q) * 32'(sfi_q);
        wgt_idx_d = 32'(uop_i[31:22]) + 32'(it_out_q) * 32'(wfo_q) + 32'(it_in_q) * 32'(wfi_q);
    end

    // Per-lane dot product; the sum wraps at ACC_WIDTH bits.
    logic signed [ACC_WIDTH-1:0] lane_sum;
    logic signed [PW-1:0]        prod;

    always_comb begin
        exe_acc_d = '0;
        exe_out_d = '0;
        lane_sum  = '0;
        prod      = '0;
        for (int i = 0; i < ACC_DEPTH; i++) begin
            lane_sum = acc_mem_rd_data_i[ACC_WIDTH*i +: ACC_WIDTH];
            for (int j = 0; j < INP_DEPTH; j++) begin
                prod = $signed(inp_mem_rd_data_i[INP_WIDTH*j +: INP_WIDTH]) *
                       $signed(wgt_mem_rd_data_i[WGT_WIDTH*(INP_DEPTH*i+j) +: WGT_WIDTH]);
                lane_sum = lane_sum + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
            end
            if (reset_reg_q) lane_sum = '0;
            exe_acc_d[ACC_WIDTH*i +: ACC_WIDTH] = lane_sum;
`ifdef GEMM_CORE_SAT_EN
            if (lane_sum > SAT_MAX) begin
                exe_out_d[INP_WIDTH*i +: INP_WIDTH] = 8'h7F;
            end else if (lane_sum < SAT_MIN) begin
                exe_out_d[INP_WIDTH*i +: INP_WIDTH] = 8'h80;
            end else begin
                exe_out_d[INP_WIDTH*i +: INP_WIDTH] = lane_sum[INP_WIDTH-1:0];
            end
`else
            exe_out_d[INP_WIDTH*i +: INP_WIDTH] = lane_sum[INP_WIDTH-1:0];
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reset_reg_q   <= 1'b0;
            bgn_q         <= '0;
            end_q         <= '0;
            iter_out_q    <= '0;
            iter_in_q     <= '0;
            dfo_q         <= '0;
            dfi_q         <= '0;
            sfo_q         <= '0;
            sfi_q         <= '0;
            wfo_q         <= '0;
            wfi_q         <= '0;
            it_out_q      <= '0;
            it_in_q       <= '0;
            upc_q         <= '0;
            acc_idx_q     <= '0;
            inp_idx_q     <= '0;
            wgt_idx_q     <= '0;
            acc_wr_data_q <= '0;
            out_wr_data_q <= '0;
            acc_wr_addr_q <= '0;
            we_q          <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (is_gemm) begin
                        reset_reg_q <= insn_i[7];
                        bgn_q       <= insn_i[20:8];
                        end_q       <= insn_i[34:21];
                        iter_out_q  <= insn_i[48:35];
                        iter_in_q   <= insn_i[62:49];
                        dfo_q       <= insn_i[73:63];
                        dfi_q       <= insn_i[84:74];
                        sfo_q       <= insn_i[95:85];
                        sfi_q       <= insn_i[106:96];
                        wfo_q       <= insn_i[116:107];
                        wfi_q       <= insn_i[126:117];
                        upc_q       <= insn_i[20:8];
                        it_out_q    <= '0;
                        it_in_q     <= '0;
                    end
                end
                ST_IDX: begin
                    acc_idx_q <= acc_idx_d;
                    inp_idx_q <= inp_idx_d;
                    wgt_idx_q <= wgt_idx_d;
                end
                ST_EXE: begin
                    acc_wr_data_q <= exe_acc_d;
                    out_wr_data_q <= exe_out_d;
                    acc_wr_addr_q <= acc_idx_q[11:0];
                    we_q          <= 1'b1;
                    // Inner loop is the uop range, then it_in, then it_out.
                    if (last_upc) begin
                        upc_q <= bgn_q;
                        if (last_in) begin
                            it_in_q  <= '0;
                            it_out_q <= it_out_q + 14'd1;
                        end else begin
                            it_in_q <= it_in_q + 14'd1;
                        end
                    end else begin
                        upc_q <= upc_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign upc_o             = upc_q;
    assign acc_mem_rd_addr_o = acc_idx_q[11:0];
    assign inp_mem_rd_addr_o = inp_idx_q;
    assign wgt_mem_rd_addr_o = wgt_idx_q;
    assign acc_mem_wr_data_o = acc_wr_data_q;
    assign acc_mem_wr_addr_o = acc_wr_addr_q;
    assign acc_mem_wr_we_o   = {(ACC_DEPTH*ACC_WIDTH/8){we_q}};
    assign out_mem_wr_data_o = out_wr_data_q;
    assign out_mem_wr_addr_o = {20'd0, acc_wr_addr_q};
    assign out_mem_wr_we_o   = {32{we_q}};

endmodule

// File: tb/tb_gemm_core.sv
// Scoreboard bench for gemm_core: RAM models plus directed instructions;
// a monitor compares every write strobe against queued expectations.
module tb_gemm_core;

    logic          clk = 1'b0;
    logic          rst;
    logic [127:0]  insn;
    logic [31:0]   uop_rd;
    logic [12:0]   upc;
    logic [511:0]  acc_rd;
    logic [11:0]   acc_rd_addr;
    logic [511:0]  acc_wr_data;
    logic [11:0]   acc_wr_addr;
    logic [63:0]   acc_we;
    logic [127:0]  inp_rd;
    logic [31:0]   inp_addr;
    logic [2047:0] wgt_rd;
    logic [31:0]   wgt_addr;
    logic [127:0]  out_data;
    logic [31:0]   out_addr;
    logic [31:0]   out_we;

    always #5 clk = ~clk;

    gemm_core dut (
        .clk_i(clk), .rst_i(rst), .insn_i(insn), .uop_i(uop_rd), .upc_o(upc),
        .acc_mem_rd_data_i(acc_rd), .acc_mem_rd_addr_o(acc_rd_addr),
        .acc_mem_wr_data_o(acc_wr_data), .acc_mem_wr_addr_o(acc_wr_addr),
        .acc_mem_wr_we_o(acc_we), .inp_mem_rd_data_i(inp_rd),
        .inp_mem_rd_addr_o(inp_addr), .wgt_mem_rd_data_i(wgt_rd),
        .wgt_mem_rd_addr_o(wgt_addr), .out_mem_wr_data_o(out_data),
        .out_mem_wr_addr_o(out_addr), .out_mem_wr_we_o(out_we)
    );

    typedef struct {
        int unsigned  cyc;
        logic [11:0]  addr;
        logic [511:0] acc;
        logic [127:0] out;
    } exp_t;

    exp_t        sb[$];
    int          checks;
    int          errors;
    int          writes;
    int unsigned cyc;

    logic [31:0]   uop_mem[16];
    logic [511:0]  acc_mem[64];
    logic [127:0]  inp_mem[16];
    logic [2047:0] wgt_mem[16];

    function automatic logic [511:0] row32(int v);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = 32'(v);
        return r;
    endfunction

    function automatic logic [127:0] row8(logic [7:0] v);
        return {16{v}};
    endfunction

    function automatic logic [2047:0] tile8(logic [7:0] v);
        return {256{v}};
    endfunction

    function automatic logic [31:0] mk_uop(int acc, int inp, int wgt);
        logic [31:0] u;
        u[10:0]  = acc[10:0];
        u[21:11] = inp[10:0];
        u[31:22] = wgt[9:0];
        return u;
    endfunction

    function automatic logic [127:0] mk_insn(bit rr, int bgn, int en, int io, int ii,
                                             int dfo, int dfi);
        logic [127:0] v;
        v          = '0;
        v[2:0]     = 3'd2;
        v[7]       = rr;
        v[20:8]    = bgn[12:0];
        v[34:21]   = en[13:0];
        v[48:35]   = io[13:0];
        v[62:49]   = ii[13:0];
        v[73:63]   = dfo[10:0];
        v[84:74]   = dfi[10:0];
        return v;
    endfunction

    task automatic check(string name, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(int unsigned c, int addr, logic [511:0] a, logic [127:0] o);
        exp_t e;
        e.cyc  = c;
        e.addr = addr[11:0];
        e.acc  = a;
        e.out  = o;
        sb.push_back(e);
    endtask

    task automatic start(logic [127:0] ins, output int unsigned t0);
        @(negedge clk);
        insn = ins;
        t0   = cyc + 1;
    endtask

    task automatic finish(string name, int hold);
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d writes still pending, required 0", name, sb.size());
            sb.delete();
        end
        repeat (hold) @(negedge clk);
        insn = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int unsigned  t0;
        int           w0;
        int           k;
        logic [511:0] ea;
        logic [127:0] eo;

        checks = 0; errors = 0; writes = 0; cyc = 0;
        rst = 1'b1; insn = '0;
        uop_rd = '0; acc_rd = '0; inp_rd = '0; wgt_rd = '0;
        for (int i = 0; i < 16; i++) begin
            uop_mem[i] = '0; inp_mem[i] = '0; wgt_mem[i] = '0;
        end
        for (int i = 0; i < 64; i++) acc_mem[i] = '0;

        fork
            forever begin
                @(posedge clk);
                cyc    <= cyc + 1;
                uop_rd <= uop_mem[upc[3:0]];
                acc_rd <= acc_mem[acc_rd_addr[5:0]];
                inp_rd <= inp_mem[inp_addr[3:0]];
                wgt_rd <= wgt_mem[wgt_addr[3:0]];
                if (acc_we[0]) acc_mem[acc_wr_addr[5:0]] <= acc_wr_data;
            end
            forever begin
                exp_t e;
                @(negedge clk);
                if (acc_we != '0 || out_we != '0) begin
                    writes++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr %0d at cycle %0d, required no write",
                                 acc_wr_addr, cyc);
                    end else begin
                        e = sb.pop_front();
                        check("wr_cycle", 512'(cyc), 512'(e.cyc));
                        check("acc_we", 512'(acc_we), 512'({64{1'b1}}));
                        check("out_we", 512'(out_we), 512'({32{1'b1}}));
                        check("acc_addr", 512'(acc_wr_addr), 512'(e.addr));
                        check("out_addr", 512'(out_addr), 512'(e.addr));
                        check("acc_data", acc_wr_data, e.acc);
                        check("out_data", 512'(out_data), 512'(e.out));
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("reset_ctrl", 512'({upc, acc_rd_addr, inp_addr, wgt_addr, acc_wr_addr,
                                  acc_we, out_addr, out_we, out_data}), '0);
        check("reset_acc_wr", acc_wr_data, '0);
        rst = 1'b0;

        // Single uop: 5 + 16*1*2 = 37, held opcode must not re-execute.
        acc_mem[0] = row32(5);
        inp_mem[0] = row8(8'd1);
        wgt_mem[0] = tile8(8'd2);
        uop_mem[0] = mk_uop(0, 0, 0);
        start(mk_insn(1'b0, 0, 1, 1, 1, 0, 0), t0);
        push(t0 + 4, 0, row32(37), row8(8'h25));
        finish("single", 10);

        // reset_reg forces zero regardless of RAM data.
        start(mk_insn(1'b1, 0, 1, 1, 1, 0, 0), t0);
        push(t0 + 4, 0, '0, '0);
        finish("reset_reg", 4);

        // Signed: each lane adds 16*(-1*100) = -1600.
        ea = '0; eo = '0;
        for (int i = 0; i < 15; i++) begin
            acc_mem[3][32*i +: 32] = 32'(1600 + 10*i);
            ea[32*i +: 32] = 32'(10*i);
`ifdef GEMM_CORE_SAT_EN
            eo[8*i +: 8] = (10*i > 127) ? 8'h7F : 8'(10*i);
`else
            eo[8*i +: 8] = 8'(10*i);
`endif
        end
        acc_mem[3][32*15 +: 32] = 32'd5;
        ea[32*15 +: 32] = 32'hFFFF_F9C5;
`ifdef GEMM_CORE_SAT_EN
        eo[8*15 +: 8] = 8'h80;
`else
        eo[8*15 +: 8] = 8'hC5;
`endif
        inp_mem[2] = row8(8'hFF);
        wgt_mem[4] = tile8(8'd100);
        uop_mem[1] = mk_uop(3, 2, 4);
        start(mk_insn(1'b0, 1, 2, 1, 1, 0, 0), t0);
        push(t0 + 4, 3, ea, eo);
        finish("signed", 4);

        // Loop nest: uop2 adds 32, uop3 adds 16*2*2 = 64; row r starts at r.
        inp_mem[1] = row8(8'd2);
        wgt_mem[1] = tile8(8'd2);
        uop_mem[2] = mk_uop(16, 0, 0);
        uop_mem[3] = mk_uop(32, 1, 1);
        for (int o = 0; o < 2; o++)
            for (int n = 0; n < 3; n++) begin
                acc_mem[16 + 8*o + n] = row32(16 + 8*o + n);
                acc_mem[32 + 8*o + n] = row32(32 + 8*o + n);
            end
        start(mk_insn(1'b0, 2, 4, 2, 3, 8, 1), t0);
        k = 0;
        for (int o = 0; o < 2; o++)
            for (int n = 0; n < 3; n++) begin
                push(t0 + 4 + 4*k, 16 + 8*o + n, row32(48 + 8*o + n), row8(8'(48 + 8*o + n)));
                k++;
                push(t0 + 4 + 4*k, 32 + 8*o + n, row32(96 + 8*o + n), row8(8'(96 + 8*o + n)));
                k++;
            end
        finish("loop_nest", 4);

        // Same row twice back to back: 5 -> 37 -> 69.
        acc_mem[5] = row32(5);
        uop_mem[4] = mk_uop(5, 0, 0);
        start(mk_insn(1'b0, 4, 5, 1, 2, 0, 0), t0);
        push(t0 + 4, 5, row32(37), row8(8'h25));
        push(t0 + 8, 5, row32(69), row8(8'h45));
        finish("same_row", 4);

        // Degenerate instructions held for a while: no strobes.
        w0 = writes;
        start(mk_insn(1'b0, 1, 1, 1, 1, 0, 0), t0);
        finish("degen_range", 20);
        check("degen_range_writes", 512'(writes), 512'(w0));
        start(mk_insn(1'b0, 0, 1, 1, 0, 0, 0), t0);
        finish("degen_iter", 20);
        check("degen_iter_writes", 512'(writes), 512'(w0));

        // Core is back in IDLE: row 0 (zeroed earlier) gets 32.
        start(mk_insn(1'b0, 0, 1, 1, 1, 0, 0), t0);
        push(t0 + 4, 0, row32(32), row8(8'h20));
        finish("after_degen", 4);

        // Reset during RD of the first step aborts everything.
        w0 = writes;
        start(mk_insn(1'b0, 2, 4, 2, 3, 8, 1), t0);
        repeat (3) @(negedge clk);
        rst  = 1'b1;
        insn = '0;
        @(negedge clk);
        check("midrst_ctrl", 512'({upc, acc_rd_addr, inp_addr, wgt_addr, acc_wr_addr,
                                   acc_we, out_addr, out_we, out_data}), '0);
        check("midrst_acc_wr", acc_wr_data, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_writes", 512'(writes), 512'(w0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
